// File: rtl/serpar_pkg.sv
// Shared types and constants for the serial link serializer/deserializer pair.
package serpar_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int idx_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register: loads a completed word the cycle after word_vld.
// A word arriving while the held word is stalled is dropped and flagged (sticky overflow).
module deser_out_buf
  import serpar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_vld,
  input  logic [DATA_W-1:0] word_dat,
  input  logic              par_ready,
  output logic [DATA_W-1:0] par_out,
  output logic              par_valid,
  output logic              overflow,
  output logic              load
);

  // A consume on the same edge frees the slot, so back-to-back words load without a bubble.
  assign load = word_vld && (!par_valid || par_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_out   <= '0;
      par_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        par_out   <= word_dat;
        par_valid <= 1'b1;
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end
      if (word_vld && par_valid && !par_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer: word appears one cycle after its last bit; stalled output drops new words.
// Framing errors (misplaced ser_first) and overflow are sticky until reset.
module serial_to_parallel
  import serpar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              ser_first,
  output logic [DATA_W-1:0] par_out,
  output logic              par_valid,
  input  logic              par_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int IW = idx_w(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] sreg;
  logic              word_vld;
  logic [DATA_W-1:0] word_dat;
  logic              load;

  assign word_vld = ser_valid && !ser_first && (state == SHIFT) && (idx == LAST);

  always_comb begin
    word_dat           = sreg;
    word_dat[DATA_W-1] = ser_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else if (ser_valid) begin
      if (ser_first) begin
        // A new start while mid-word abandons the partial word.
        if (state == SHIFT) frame_err <= 1'b1;
        sreg[0] <= ser_in;
        idx     <= IW'(1);
        state   <= SHIFT;
      end else if (state == IDLE) begin
        frame_err <= 1'b1;
      end else begin
        sreg[idx] <= ser_in;
        if (idx == LAST) begin
          idx   <= '0;
          state <= IDLE;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  deser_out_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_vld  (word_vld),
    .word_dat  (word_dat),
    .par_ready (par_ready),
    .par_out   (par_out),
    .par_valid (par_valid),
    .overflow  (overflow),
    .load      (load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (load) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized and directed bench for serial_to_parallel against a queue-based word model.
module tb_serial_to_parallel;
  import serpar_pkg::*;

  localparam int W  = DATA_W_DEF;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ser_in = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_first = 1'b0;
  logic [W-1:0]  par_out;
  logic          par_valid;
  logic          par_ready = 1'b1;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] byte_cnt;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  serial_to_parallel #(.DATA_W(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .par_out   (par_out),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Behavioural model: a queue of bits received since the last start marker.
  logic         m_part[$];
  logic [W-1:0] m_po;
  logic [W-1:0] m_word;
  logic         m_pv, m_fe, m_ov, m_done;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_part.delete();
      m_po = '0; m_pv = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      m_word = '0;
      if (ser_valid) begin
        if (ser_first) begin
          if (m_part.size() != 0) m_fe = 1'b1;
          m_part.delete();
          m_part.push_back(ser_in);
        end else if (m_part.size() == 0) begin
          m_fe = 1'b1;
        end else begin
          m_part.push_back(ser_in);
          if (m_part.size() == W) begin
            for (int k = 0; k < W; k++) m_word[k] = m_part[k];
            m_part.delete();
            m_done = 1'b1;
          end
        end
      end
      if (m_done) begin
        if (!m_pv || par_ready) begin
          m_po = m_word; m_pv = 1'b1; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_pv && par_ready) begin
        m_pv = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison plus a delivery log for spacing checks.
  int           dlv_cyc[$];
  logic [W-1:0] dlv_dat[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_par_valid", 32'(par_valid), 32'(m_pv));
      chk("mon_frame_err", 32'(frame_err), 32'(m_fe));
      chk("mon_overflow", 32'(overflow), 32'(m_ov));
      chk("mon_byte_cnt", 32'(byte_cnt), 32'(m_cnt));
      if (m_pv) chk("mon_par_out", 32'(par_out), 32'(m_po));
      if (par_valid && par_ready) begin
        dlv_cyc.push_back(cycle);
        dlv_dat.push_back(par_out);
      end
    end
  end

  task automatic idle1();
    @(negedge clk);
    ser_valid = 1'b0;
    ser_first = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic first);
    @(negedge clk);
    ser_valid = 1'b1;
    ser_in    = b;
    ser_first = first;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) idle1();
      send_bit(w[i], i == 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ser_valid = 1'b0; ser_first = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pos;
  int rdy_pct;

  initial begin
    do_reset();
    chk("rst_par_valid", 32'(par_valid), 32'h0);
    chk("rst_par_out", 32'(par_out), 32'h0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'h0);
    chk("rst_flags", 32'({frame_err, overflow}), 32'h0);

    // 0xA5 contiguous
    par_ready = 1'b1;
    send_word(8'hA5, 0);
    idle1();
    chk("a5_valid", 32'(par_valid), 32'h1);
    chk("a5_data", 32'(par_out), 32'hA5);
    chk("a5_model", 32'(m_po), 32'hA5);
    idle1();
    chk("a5_valid_drop", 32'(par_valid), 32'h0);
    chk("a5_cnt", 32'(byte_cnt), 32'h1);
    chk("a5_flags", 32'({frame_err, overflow}), 32'h0);

    // 0x3C with 3-cycle gaps
    do_reset();
    send_word(8'h3C, 3);
    idle1();
    chk("3c_valid", 32'(par_valid), 32'h1);
    chk("3c_data", 32'(par_out), 32'h3C);
    idle1();
    chk("3c_one_cycle", 32'(par_valid), 32'h0);
    chk("3c_frame_err", 32'(frame_err), 32'h0);

    // Overflow while stalled
    do_reset();
    par_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    idle1();
    chk("ovf_valid", 32'(par_valid), 32'h1);
    chk("ovf_hold", 32'(par_out), 32'h11);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_cnt", 32'(byte_cnt), 32'h1);
    chk("ovf_model", 32'({m_ov, m_po}), 32'h111);
    @(negedge clk); par_ready = 1'b1;
    @(negedge clk); par_ready = 1'b0;
    chk("ovf_consumed", 32'(par_valid), 32'h0);
    chk("ovf_no_22", 32'(par_out), 32'h11);
    par_ready = 1'b1;

    // Restart mid-word
    do_reset();
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    send_word(8'h5A, 0);
    idle1();
    chk("restart_fe", 32'(frame_err), 32'h1);
    chk("restart_data", 32'(par_out), 32'h5A);
    chk("restart_valid", 32'(par_valid), 32'h1);
    chk("restart_cnt", 32'(byte_cnt), 32'h1);

    // Stray bit in IDLE
    do_reset();
    send_bit(1'b1, 1'b0);
    idle1();
    chk("stray_fe", 32'(frame_err), 32'h1);
    repeat (3) idle1();
    chk("stray_no_word", 32'({par_valid, byte_cnt}), 32'h0);

    // 0x01 then 0xFF back-to-back
    do_reset();
    dlv_cyc.delete(); dlv_dat.delete();
    send_word(8'h01, 0);
    send_word(8'hFF, 0);
    repeat (2) idle1();
    chk("b2b_count", 32'(dlv_cyc.size()), 32'h2);
    if (dlv_cyc.size() == 2) begin
      chk("b2b_spacing", 32'(dlv_cyc[1] - dlv_cyc[0]), 32'd8);
      chk("b2b_first", 32'(dlv_dat[0]), 32'h01);
      chk("b2b_second", 32'(dlv_dat[1]), 32'hFF);
    end
    chk("b2b_cnt", 32'(byte_cnt), 32'h2);
    chk("b2b_ovf", 32'(overflow), 32'h0);

    // Asynchronous reset after 5 bits, with previous word still visible
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({par_valid, frame_err, overflow}), 32'h0);
    chk("arst_data", 32'(par_out), 32'h0);
    chk("arst_cnt", 32'(byte_cnt), 32'h0);
    @(negedge clk); ser_valid = 1'b0; ser_first = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send_word(8'hC3, 0);
    idle1();
    chk("post_rst_data", 32'(par_out), 32'hC3);
    chk("post_rst_cnt", 32'(byte_cnt), 32'h1);
    chk("post_rst_fe", 32'(frame_err), 32'h0);

    // Randomized traffic with occasional framing faults and varying backpressure
    do_reset();
    pos = 0;
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 2))
        0:       rdy_pct = 10;
        1:       rdy_pct = 60;
        default: rdy_pct = 100;
      endcase
      if (blk == 7) do_reset();
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        par_ready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 9) < 7) begin
          ser_valid = 1'b1;
          ser_in    = 1'($urandom_range(0, 1));
          ser_first = (pos == 0) ^ ($urandom_range(0, 39) == 0);
          pos       = ser_first ? 1 : (pos + 1) % W;
        end else begin
          ser_valid = 1'b0;
          ser_first = 1'b0;
        end
      end
    end
    idle1();
    idle1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
